// File: rtl/sar_adc_pkg.sv
// Shared types and counter-width helper for the SAR ADC controller.
// Pure declarations: no logic, no latency, no flow control.
package sar_adc_pkg;

   typedef enum logic [1:0] {IDLE, SAMPLE, BIT, DONE} sar_state_t;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser, async active-low reset to 0.
// Latency 2 cycles; no flow control.
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR conversion controller: track/hold, MSB-first bit trials, registered result with done pulse.
// Done arrives SAMPLE_CYCLES + WIDTH*SETTLE + 1 cycles after start; start is ignored unless idle.
module sar_adc_ctrl
   import sar_adc_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter int SAMPLE_CYCLES = 2,
   parameter int SETTLE        = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             start,
   input  logic             cmp_in,
   output logic             sample,
   output logic [WIDTH-1:0] dac_code,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             valid
);

   localparam int IW = cnt_w(WIDTH);
   localparam int SW = cnt_w(SETTLE);
   localparam int CW = cnt_w(SAMPLE_CYCLES);

   sar_state_t       state;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] next_work;
   logic [IW-1:0]    idx;
   logic [SW-1:0]    settle_cnt;
   logic [CW-1:0]    sample_cnt;
   logic             cmp_s;

   sync2 u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (cmp_in),
      .q     (cmp_s)
   );

   always_comb begin
      mask      = WIDTH'(1) << idx;
      next_work = cmp_s ? (work | mask) : work;
   end

   // Outputs are assigned alongside the state they belong to, so they are valid in that state's first cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         work       <= '0;
         idx        <= '0;
         settle_cnt <= '0;
         sample_cnt <= '0;
         sample     <= 1'b0;
         dac_code   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         result     <= '0;
         valid      <= 1'b0;
      end else if (!ena) begin
         state      <= IDLE;
         work       <= '0;
         idx        <= '0;
         settle_cnt <= '0;
         sample_cnt <= '0;
         sample     <= 1'b0;
         dac_code   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state      <= SAMPLE;
                  valid      <= 1'b0;
                  work       <= '0;
                  idx        <= IW'(WIDTH - 1);
                  sample_cnt <= '0;
                  sample     <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            SAMPLE: begin
               if (sample_cnt == CW'(SAMPLE_CYCLES - 1)) begin
                  state      <= BIT;
                  sample     <= 1'b0;
                  settle_cnt <= '0;
                  dac_code   <= mask;
               end else begin
                  sample_cnt <= sample_cnt + CW'(1);
               end
            end
            BIT: begin
               if (settle_cnt == SW'(SETTLE - 1)) begin
                  work       <= next_work;
                  settle_cnt <= '0;
                  if (idx == '0) begin
                     state    <= DONE;
                     result   <= next_work;
                     done     <= 1'b1;
                     valid    <= 1'b1;
                     dac_code <= '0;
                  end else begin
                     idx      <= idx - IW'(1);
                     dac_code <= next_work | (mask >> 1);
                  end
               end else begin
                  settle_cnt <= settle_cnt + SW'(1);
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: ideal comparator, cycle-level reference model plus directed literal checks.
module tb_sar_adc_ctrl;

   localparam int W      = 8;
   localparam int SC     = 2;
   localparam int ST     = 3;
   localparam int DONE_N = SC + W * ST + 1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         ena;
   logic         start;
   logic         cmp_in;
   logic         sample;
   logic [W-1:0] dac_code;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         valid;
   logic [W-1:0] vin;

   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;
   bit chk_on = 1'b0;

   logic [7:0] trials_00 [8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
   logic [7:0] trials_ff [8] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};

   sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(SC), .SETTLE(ST)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .start    (start),
      .cmp_in   (cmp_in),
      .sample   (sample),
      .dac_code (dac_code),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .valid    (valid)
   );

   always #5 clk = ~clk;

   assign cmp_in = (vin >= dac_code);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Ideal SAR: after i decisions the working value is vin with the low W-i bits cleared.
   function automatic logic [7:0] exp_dac(input int n, input logic [7:0] v);
      int         i;
      logic [7:0] hi;
      if (n <= SC || n > SC + W * ST) return 8'h00;
      i  = (n - SC - 1) / ST;
      hi = 8'(~((1 << (W - i)) - 1));
      return (v & hi) | 8'(1 << (W - 1 - i));
   endfunction

   // m_n is the cycle number (1 = first cycle after acceptance) of the period now in progress.
   bit         m_active;
   int         m_n;
   logic [7:0] m_vin;
   logic [7:0] m_result;
   bit         m_valid;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 1'b0;
         m_n      = 0;
         m_vin    = 8'h00;
         m_result = 8'h00;
         m_valid  = 1'b0;
      end else if (!ena) begin
         m_active = 1'b0;
      end else if (!m_active) begin
         if (start) begin
            m_active = 1'b1;
            m_n      = 1;
            m_valid  = 1'b0;
            m_vin    = vin;
         end
      end else begin
         m_n++;
         if (m_n == DONE_N) begin
            m_result = m_vin;
            m_valid  = 1'b1;
         end else if (m_n > DONE_N) begin
            m_active = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && chk_on) begin
         check("model.sample", sample, m_active && m_n <= SC);
         check("model.dac", dac_code, m_active ? exp_dac(m_n, m_vin) : 8'h00);
         check("model.busy", busy, m_active);
         check("model.done", done, m_active && m_n == DONE_N);
         check("model.result", result, m_result);
         check("model.valid", valid, m_valid);
      end
   end

   always @(posedge clk) if (done === 1'b1) done_cnt++;

   task automatic wait_idle();
      int k = 0;
      while (busy !== 1'b0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("idle_timeout", k < 200, 1);
   endtask

   task automatic conv_trials(input logic [7:0] v, input bit hi);
      vin   = v;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         check("trial_code", dac_code, hi ? trials_ff[i] : trials_00[i]);
         repeat (3) @(negedge clk);
      end
      check("extreme.done", done, 1);
      check("extreme.result", result, v);
      @(negedge clk);
   endtask

   initial begin
      int base;
      rst_n = 1'b0;
      ena   = 1'b1;
      start = 1'b0;
      vin   = 8'h00;
      repeat (3) @(negedge clk);
      check("rst.sample", sample, 0);
      check("rst.dac", dac_code, 0);
      check("rst.busy", busy, 0);
      check("rst.done", done, 0);
      check("rst.result", result, 0);
      check("rst.valid", valid, 0);
      rst_n  = 1'b1;
      chk_on = 1'b1;
      @(negedge clk);

      // vin 0xA5, single start pulse
      vin   = 8'hA5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("a5.busy_c1", busy, 1);
      check("a5.sample_c1", sample, 1);
      @(negedge clk);
      check("a5.sample_c2", sample, 1);
      @(negedge clk);
      check("a5.sample_c3", sample, 0);
      check("a5.dac_c3", dac_code, 8'h80);
      repeat (24) @(negedge clk);
      check("a5.done_c27", done, 1);
      check("a5.result", result, 8'hA5);
      check("a5.valid", valid, 1);
      @(negedge clk);
      check("a5.busy_c28", busy, 0);
      check("a5.done_c28", done, 0);

      conv_trials(8'h00, 1'b0);
      conv_trials(8'hFF, 1'b1);

      // start re-pulsed mid-conversion and during the done cycle
      vin   = 8'h6B;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      base  = done_cnt;
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (21) @(negedge clk);
      check("repulse.done_c27", done, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("repulse.busy_c28", busy, 0);
      repeat (30) @(negedge clk);
      check("repulse.done_count", done_cnt - base, 1);
      check("repulse.result", result, 8'h6B);

      // start held high: back-to-back conversions with one idle cycle between
      vin   = 8'h5A;
      start = 1'b1;
      repeat (27) @(negedge clk);
      check("held.done_c27", done, 1);
      @(negedge clk);
      check("held.idle_c28", busy, 0);
      @(negedge clk);
      check("held.valid_cleared", valid, 0);
      check("held.busy_again", busy, 1);
      repeat (26) @(negedge clk);
      check("held.done_c55", done, 1);
      check("held.valid_c55", valid, 1);
      check("held.result_c55", result, 8'h5A);
      repeat (5) @(negedge clk);
      start = 1'b0;
      wait_idle();
      @(negedge clk);

      // asynchronous reset mid-conversion
      vin   = 8'h3C;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (11) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst.sample", sample, 0);
      check("arst.dac", dac_code, 0);
      check("arst.busy", busy, 0);
      check("arst.done", done, 0);
      check("arst.result", result, 0);
      check("arst.valid", valid, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (26) @(negedge clk);
      check("arst.done_after", done, 1);
      check("arst.result_after", result, 8'h3C);
      @(negedge clk);

      // enable dropped mid-conversion
      vin   = 8'h11;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      check("ena.prior_result", result, 8'h11);
      @(negedge clk);
      vin   = 8'h77;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      ena  = 1'b0;
      base = done_cnt;
      @(negedge clk);
      check("ena.busy", busy, 0);
      check("ena.dac", dac_code, 0);
      check("ena.sample", sample, 0);
      check("ena.result_kept", result, 8'h11);
      check("ena.valid", valid, 0);
      ena = 1'b1;
      repeat (30) @(negedge clk);
      check("ena.no_done", done_cnt - base, 0);
      check("ena.still_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1);
   end

endmodule
